// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES core between two requesters.
// Holds the core inputs for the whole job, times out a stuck core, and routes the result to the owner.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no job; arbitrate and accept one request
// S_ISSUE | core inputs loaded, core_start pulsed, timer cleared
// S_WAIT  | waiting for core_done or timer terminal count
// S_RESP  | result presented to owner until its rsp_ready
module aes_job_scheduler #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_decrypt,
   input  logic [127:0] req0_data,
   input  logic [127:0] req0_key,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_decrypt,
   input  logic [127:0] req1_data,
   input  logic [127:0] req1_key,

   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [127:0] rsp0_data,
   output logic         rsp0_err,

   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [127:0] rsp1_data,
   output logic         rsp1_err,

   output logic         core_start,
   output logic         core_decrypt,
   output logic [127:0] core_data,
   output logic [127:0] core_key,
   input  logic         core_done,
   input  logic [127:0] core_out,

   output logic         busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state;
   logic           owner;
   logic           last_grant;
   logic [TW-1:0]  timer;
   logic [127:0]   result;
   logic           err;

   logic           grant_vld;
   logic           grant_id;
   logic           owner_ready;

   // On a tie the requester not served last wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = ~last_grant;
      end else if (req0_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b0;
      end else if (req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b1;
      end
   end

   assign req0_ready  = !reset && (state == S_IDLE) && grant_vld && !grant_id;
   assign req1_ready  = !reset && (state == S_IDLE) && grant_vld &&  grant_id;
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;

   assign rsp0_valid  = (state == S_RESP) && !owner;
   assign rsp1_valid  = (state == S_RESP) &&  owner;
   assign rsp0_data   = rsp0_valid ? result : '0;
   assign rsp1_data   = rsp1_valid ? result : '0;
   assign rsp0_err    = rsp0_valid && err;
   assign rsp1_err    = rsp1_valid && err;
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         timer        <= '0;
         result       <= '0;
         err          <= 1'b0;
         core_start   <= 1'b0;
         core_decrypt <= 1'b0;
         core_data    <= '0;
         core_key     <= '0;
      end else begin
         core_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  owner        <= grant_id;
                  core_decrypt <= grant_id ? req1_decrypt : req0_decrypt;
                  core_data    <= grant_id ? req1_data    : req0_data;
                  core_key     <= grant_id ? req1_key     : req0_key;
                  core_start   <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            // core_done is deliberately not looked at here: a level left
            // over from the previous job must not finish this one.
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (timer != TIMER_MAX) begin
                  timer <= timer + 1'b1;
               end
               if (core_done) begin
                  result <= core_out;
                  err    <= 1'b0;
                  state  <= S_RESP;
               end else if (timer == TIMER_LAST) begin
                  result <= '0;
                  err    <= 1'b1;
                  state  <= S_RESP;
               end
            end
            S_RESP: begin
               if (owner_ready) begin
                  last_grant <= owner;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: latency, arbitration, backpressure,
// timeout, stale/simultaneous done and mid-job reset, with hand-computed expectations.
module tb_aes_job_scheduler;

   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready, req0_decrypt;
   logic [127:0] req0_data, req0_key;
   logic         req1_valid, req1_ready, req1_decrypt;
   logic [127:0] req1_data, req1_key;
   logic         rsp0_valid, rsp0_ready, rsp0_err;
   logic [127:0] rsp0_data;
   logic         rsp1_valid, rsp1_ready, rsp1_err;
   logic [127:0] rsp1_data;
   logic         core_start, core_decrypt, core_done, busy;
   logic [127:0] core_data, core_key, core_out;

   int checks = 0;
   int errors = 0;

   aes_job_scheduler #(.TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_decrypt(req0_decrypt),
      .req0_data(req0_data), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_decrypt(req1_decrypt),
      .req1_data(req1_data), .req1_key(req1_key),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .core_start(core_start), .core_decrypt(core_decrypt), .core_data(core_data),
      .core_key(core_key), .core_done(core_done), .core_out(core_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] key_a, pt_a, x_a, d0, d1, o;
      logic         exp_owner;
      key_a = 128'h987f9dc92a3c234532afdec92a3cfbc7;
      pt_a  = "ahmedamrnabil123";
      x_a   = 128'h5d1c3f0a9e2b47c688f1a2b3c4d5e6f7;

      reset = 1'b1;
      req0_valid = 0; req0_decrypt = 0; req0_data = '0; req0_key = '0;
      req1_valid = 0; req1_decrypt = 0; req1_data = '0; req1_key = '0;
      rsp0_ready = 0; rsp1_ready = 0; core_done = 0; core_out = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_data", core_data, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);

      // single encrypt: accepted at T, done sampled at T+12, response at T+13
      req0_valid = 1; req0_data = pt_a; req0_key = key_a; req0_decrypt = 0;
      #1;
      chk("enc_req0_ready", req0_ready, 1);
      chk("enc_req1_ready", req1_ready, 0);
      tick();
      req0_valid = 0;
      chk("enc_start_t1", core_start, 1);
      chk("enc_busy", busy, 1);
      chk("enc_core_data", core_data, pt_a);
      chk("enc_core_key", core_key, key_a);
      chk("enc_core_dec", core_decrypt, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("enc_start_low", core_start, 0);
         chk("enc_rsp0_early", rsp0_valid, 0);
         tick();
      end
      core_done = 1; core_out = x_a;
      tick();
      core_done = 0;
      chk("enc_rsp0_valid_t13", rsp0_valid, 1);
      chk("enc_rsp0_data", rsp0_data, x_a);
      chk("enc_rsp0_err", rsp0_err, 0);
      chk("enc_rsp1_valid", rsp1_valid, 0);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("enc_rsp0_done", rsp0_valid, 0);
      chk("enc_idle", busy, 0);

      // round robin from reset: grants 0,1,0,1
      reset = 1; tick(); reset = 0;
      req0_valid = 1; req1_valid = 1; req0_decrypt = 0; req1_decrypt = 1;
      for (int j = 0; j < 4; j++) begin
         exp_owner = (j % 2) == 1;
         d0 = {96'h0, 32'hA000_0000 + 32'(j)};
         d1 = {96'h0, 32'hB000_0000 + 32'(j)};
         o  = {96'h0, 32'hC000_0000 + 32'(j)};
         req0_data = d0; req1_data = d1; req0_key = ~d0; req1_key = ~d1;
         #1;
         chk("rr_req0_ready", req0_ready, !exp_owner);
         chk("rr_req1_ready", req1_ready, exp_owner);
         tick();
         chk("rr_issue_no_ready", req0_ready | req1_ready, 0);
         chk("rr_core_dec", core_decrypt, exp_owner);
         chk("rr_core_data", core_data, exp_owner ? d1 : d0);
         chk("rr_core_key", core_key, exp_owner ? ~d1 : ~d0);
         tick();
         core_done = 1; core_out = o;
         tick();
         core_done = 0;
         chk("rr_rsp0_valid", rsp0_valid, !exp_owner);
         chk("rr_rsp1_valid", rsp1_valid, exp_owner);
         chk("rr_rsp_data", exp_owner ? rsp1_data : rsp0_data, o);
         rsp0_ready = 1; rsp1_ready = 1;
         tick();
         rsp0_ready = 0; rsp1_ready = 0;
      end
      req0_valid = 0; req1_valid = 0;

      // response backpressure on requester 1
      req1_valid = 1; req1_data = 128'h1111; req1_key = 128'h2222; req1_decrypt = 1;
      #1;
      chk("bp_req1_ready", req1_ready, 1);
      tick();
      req1_valid = 0;
      tick();
      core_done = 1; core_out = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
      tick();
      core_done = 0; core_out = 128'h7777;
      req0_valid = 1; req0_data = 128'h3333; req0_key = 128'h4444; req0_decrypt = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("bp_rsp1_valid", rsp1_valid, 1);
         chk("bp_rsp1_data", rsp1_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
         chk("bp_rsp1_err", rsp1_err, 0);
         chk("bp_busy", busy, 1);
         chk("bp_no_grant", req0_ready, 0);
         tick();
      end
      rsp1_ready = 1;
      tick();
      rsp1_ready = 0;

      // timeout on requester 0: accepted at T (R+1), err response at T+2+TO
      chk("to_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 0;
      chk("to_start", core_start, 1);
      tick();
      for (int i = 0; i < TO; i++) begin
         chk("to_rsp0_early", rsp0_valid, 0);
         tick();
      end
      chk("to_rsp0_valid", rsp0_valid, 1);
      chk("to_rsp0_data", rsp0_data, 0);
      chk("to_rsp0_err", rsp0_err, 1);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;

      // stale done held high before start (requester 1)
      core_done = 1; core_out = 128'hABCD_0000_1234;
      req1_valid = 1; req1_data = 128'h5555; req1_key = 128'h6666; req1_decrypt = 0;
      #1;
      chk("st_req1_ready", req1_ready, 1);
      tick();
      req1_valid = 0;
      chk("st_start", core_start, 1);
      chk("st_core_data", core_data, 128'h5555);
      tick();
      chk("st_not_done_in_issue", rsp1_valid, 0);
      tick();
      core_done = 0;
      chk("st_rsp1_valid", rsp1_valid, 1);
      chk("st_rsp1_err", rsp1_err, 0);
      chk("st_rsp1_data", rsp1_data, 128'hABCD_0000_1234);
      rsp1_ready = 1;
      tick();
      rsp1_ready = 0;

      // done on the timeout cycle (requester 0): done wins
      req0_valid = 1; req0_data = 128'h8888; req0_key = 128'h9999; req0_decrypt = 1;
      #1;
      chk("sim_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 0;
      tick();
      for (int i = 0; i < TO - 1; i++) begin
         tick();
      end
      chk("sim_rsp0_early", rsp0_valid, 0);
      core_done = 1; core_out = 128'hFACE_CAFE;
      tick();
      core_done = 0;
      chk("sim_rsp0_valid", rsp0_valid, 1);
      chk("sim_rsp0_err", rsp0_err, 0);
      chk("sim_rsp0_data", rsp0_data, 128'hFACE_CAFE);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;

      // reset during WAIT of a requester-1 job; requester 0 must win next tie
      req1_valid = 1; req1_data = 128'hAAAA; req1_key = 128'hBBBB; req1_decrypt = 1;
      tick();
      req1_valid = 0;
      tick(); tick();
      chk("mr_busy_before", busy, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("mr_busy", busy, 0);
      chk("mr_core_start", core_start, 0);
      chk("mr_core_dec", core_decrypt, 0);
      chk("mr_core_data", core_data, 0);
      chk("mr_core_key", core_key, 0);
      chk("mr_rsp0_valid", rsp0_valid, 0);
      chk("mr_rsp1_valid", rsp1_valid, 0);
      core_done = 1; core_out = 128'h1234;
      req0_valid = 1; req1_valid = 1; req0_data = 128'hCCCC;
      #1;
      chk("mr_req0_first", req0_ready, 1);
      chk("mr_req1_wait", req1_ready, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      chk("mr_owner_data", core_data, 128'hCCCC);
      chk("mr_no_rsp1", rsp1_valid, 0);
      core_done = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
